// File: rtl/fifo_ms_rr_sched_if.sv
// Scheduler-side bundle: multi-stream FIFO read port, service controls and downstream valid/ready.
// master = scheduler, slave = FIFO plus downstream sink.
interface fifo_ms_rr_sched_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2
);
  localparam int TAG_WIDTH = $clog2(FLUX);
  localparam int WIDTH     = DATA_WIDTH + TAG_WIDTH;

  logic [FLUX-1:0]      fifo_empty;
  logic [FLUX-1:0]      fifo_read;
  logic [WIDTH-1:0]     fifo_dout;
  logic [FLUX-1:0]      flux_en;
  logic                 halt;
  logic                 m_valid;
  logic                 m_ready;
  logic [WIDTH-1:0]     m_data;
  logic [TAG_WIDTH-1:0] m_tag;
  logic                 tag_err;

  modport master (
    input  fifo_empty, fifo_dout, flux_en, halt, m_ready,
    output fifo_read, m_valid, m_data, m_tag, tag_err
  );

  modport slave (
    output fifo_empty, fifo_dout, flux_en, halt, m_ready,
    input  fifo_read, m_valid, m_data, m_tag, tag_err
  );
endinterface

// File: rtl/fifo_ms_rr_sched.sv
// Burst-limited round-robin pop scheduler feeding a one-entry output register (pop lands in m_data
// at the read edge); pops stall while the register is full and m_ready is low, or on halt.
module fifo_ms_rr_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int BURST      = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_ms_rr_sched_if.master bus
);
  localparam int TAG_WIDTH = $clog2(FLUX);
  localparam int WIDTH     = DATA_WIDTH + TAG_WIDTH;
  localparam int CNT_W     = $clog2(BURST + 1);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t               state;
  logic [TAG_WIDTH-1:0] cur;
  logic [TAG_WIDTH-1:0] sel;
  logic [CNT_W-1:0]     burst_cnt;
  logic [FLUX-1:0]      eligible;
  logic                 found;
  logic                 space;
  logic                 pop;
  int                   idx;

  assign eligible    = bus.flux_en & ~bus.fifo_empty & {FLUX{~bus.halt}};
  assign space       = (state == S_EMPTY) | bus.m_ready;
  assign pop         = rst & space & found;
  assign bus.m_valid = (state == S_FULL);

  // burst_cnt==0 only after reset: no burst owner yet, so the search starts at cur+1 (stream 0).
  always_comb begin
    sel   = cur;
    found = 1'b0;
    idx   = 0;
    if (eligible[cur] && burst_cnt != '0 && int'(burst_cnt) < BURST) begin
      found = 1'b1;
    end else begin
      for (int i = 1; i < FLUX; i++) begin
        idx = int'(cur) + i;
        if (idx >= FLUX) idx = idx - FLUX;
        if (!found && eligible[idx]) begin
          sel   = idx[TAG_WIDTH-1:0];
          found = 1'b1;
        end
      end
      if (!found && eligible[cur]) begin
        sel   = cur;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    bus.fifo_read = '0;
    if (pop) bus.fifo_read[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_EMPTY;
      bus.m_data  <= '0;
      bus.m_tag   <= '0;
      bus.tag_err <= 1'b0;
      cur         <= TAG_WIDTH'(FLUX - 1);
      burst_cnt   <= '0;
    end else if (pop) begin
      state      <= S_FULL;
      bus.m_data <= bus.fifo_dout;
      bus.m_tag  <= sel;
      if (bus.fifo_dout[WIDTH-1 -: TAG_WIDTH] != sel) bus.tag_err <= 1'b1;
      if (sel != cur) begin
        cur       <= sel;
        burst_cnt <= CNT_W'(1);
      end else if (int'(burst_cnt) < BURST) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end else if (bus.m_ready) begin
      state <= S_EMPTY;
    end
  end
endmodule

// File: tb/tb_fifo_ms_rr_sched.sv
// Randomised and directed bench for fifo_ms_rr_sched: per-stream FIFO model, reference scheduler
// computed from queue occupancies, and a scoreboard of expected output beats.
module tb_fifo_ms_rr_sched;
  localparam int DATA_WIDTH = 8;
  localparam int FLUX       = 2;
  localparam int BURST      = 4;
  localparam int TAG_WIDTH  = $clog2(FLUX);
  localparam int WIDTH      = DATA_WIDTH + TAG_WIDTH;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               tag;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fifo_ms_rr_sched_if #(.DATA_WIDTH(DATA_WIDTH), .FLUX(FLUX)) bus ();

  fifo_ms_rr_sched #(.DATA_WIDTH(DATA_WIDTH), .FLUX(FLUX), .BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source FIFOs feeding the DUT
  logic [WIDTH-1:0] mem [FLUX][256];
  logic [7:0]       rd_ptr [FLUX];
  logic [7:0]       wr_ptr [FLUX];

  initial begin
    for (int s = 0; s < FLUX; s++) begin
      rd_ptr[s] = '0;
      wr_ptr[s] = '0;
    end
  end

  always @(posedge clk) begin
    for (int s = 0; s < FLUX; s++)
      if (bus.fifo_read[s]) rd_ptr[s] <= rd_ptr[s] + 8'd1;
  end

  always_comb begin
    bus.fifo_empty = '0;
    bus.fifo_dout  = '0;
    for (int s = 0; s < FLUX; s++) begin
      bus.fifo_empty[s] = (rd_ptr[s] == wr_ptr[s]);
      if (bus.fifo_read[s]) bus.fifo_dout = mem[s][rd_ptr[s]];
    end
  end

  // Reference model state
  logic [WIDTH-1:0] mq [FLUX][$];
  beat_t            exp_q [$];
  int               pop_log [$];
  int               m_cur = FLUX - 1;
  int               m_cnt = 0;
  bit               m_err = 1'b0;
  bit               prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input bit [FLUX-1:0] el, input int cur, input int cnt);
    if (el[cur] && cnt > 0 && cnt < BURST) return cur;
    for (int i = 1; i < FLUX; i++)
      if (el[(cur + i) % FLUX]) return (cur + i) % FLUX;
    if (el[cur]) return cur;
    return -1;
  endfunction

  always @(negedge clk or negedge rst) begin
    bit              vld_m;
    bit              space_m;
    bit [FLUX-1:0]   el;
    logic [FLUX-1:0] exp_rd;
    int              s;
    beat_t           b;
    logic [WIDTH-1:0] d;
    if (!rst) begin
      exp_q.delete();
      m_cur     = FLUX - 1;
      m_cnt     = 0;
      m_err     = 1'b0;
      prev_hold = 1'b0;
    end else begin
      vld_m = (exp_q.size() != 0);
      chk("m_valid", 32'(bus.m_valid), 32'(vld_m));
      chk("tag_err", 32'(bus.tag_err), 32'(m_err));
      if (prev_hold) chk("hold_data", 32'(bus.m_data), 32'(prev_data));
      if (bus.m_valid && bus.m_ready && vld_m) begin
        b = exp_q.pop_front();
        chk("m_data", 32'(bus.m_data), 32'(b.data));
        chk("m_tag", 32'(bus.m_tag), 32'(b.tag));
      end
      prev_hold = bus.m_valid && !bus.m_ready;
      prev_data = bus.m_data;

      space_m = !vld_m || bus.m_ready;
      for (int k = 0; k < FLUX; k++)
        el[k] = bus.flux_en[k] && (mq[k].size() != 0) && !bus.halt;
      s = space_m ? pick(el, m_cur, m_cnt) : -1;
      exp_rd = '0;
      if (s >= 0) begin
        exp_rd[s] = 1'b1;
        d = mq[s].pop_front();
        exp_q.push_back('{data: d, tag: s});
        if (int'(d[WIDTH-1 -: TAG_WIDTH]) != s) m_err = 1'b1;
        m_cnt = (s == m_cur) ? ((m_cnt + 1 > BURST) ? BURST : m_cnt + 1) : 1;
        m_cur = s;
      end
      chk("fifo_read", 32'(bus.fifo_read), 32'(exp_rd));
      for (int k = 0; k < FLUX; k++)
        if (bus.fifo_read[k]) pop_log.push_back(k);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input int s, input logic [WIDTH-1:0] d);
    mem[s][wr_ptr[s]] = d;
    wr_ptr[s] = wr_ptr[s] + 8'd1;
    mq[s].push_back(d);
  endtask

  task automatic push_ok(input int s);
    logic [WIDTH-1:0] d;
    d = WIDTH'($urandom_range(0, 255));
    d[WIDTH-1 -: TAG_WIDTH] = TAG_WIDTH'(s);
    push(s, d);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.m_valid && n < 20) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.m_valid), 32'd1);
  endtask

  initial begin
    int exp_a [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    logic [WIDTH-1:0] bad;
    bus.m_ready = 1'b1;
    bus.flux_en = '1;
    bus.halt    = 1'b0;

    // Reset with both streams loaded: no pop may leak out
    tick(2);
    for (int i = 0; i < 10; i++) begin
      push_ok(0);
      push_ok(1);
    end
    #1;
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
    chk("rst_m_tag", 32'(bus.m_tag), 32'd0);
    chk("rst_tag_err", 32'(bus.tag_err), 32'd0);
    chk("rst_fifo_read", 32'(bus.fifo_read), 32'd0);
    tick();
    pop_log.delete();
    rst = 1'b1;

    // Burst order across two full streams
    tick(24);
    chk("burst_pops", 32'(pop_log.size()), 32'd20);
    for (int i = 0; i < 10 && i < pop_log.size(); i++)
      chk("burst_order", 32'(pop_log[i]), 32'(exp_a[i]));

    // Lone stream 1 keeps being served past BURST
    pop_log.delete();
    for (int i = 0; i < 6; i++) push_ok(1);
    tick(10);
    chk("solo_pops", 32'(pop_log.size()), 32'd6);
    for (int i = 0; i < pop_log.size(); i++)
      chk("solo_stream", 32'(pop_log[i]), 32'd1);

    // Backpressure: held beat, no pops, pop resumes with m_ready
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_ok(0);
      push_ok(1);
    end
    wait_valid("bp_valid");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_no_read", 32'(bus.fifo_read), 32'd0);
    end
    bus.m_ready = 1'b1;
    #1;
    chk("bp_resume_pop", 32'(|bus.fifo_read), 32'd1);
    tick(10);

    // Halt blocks pops, held beat still drains
    bus.m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_ok(0);
      push_ok(1);
    end
    wait_valid("halt_valid");
    bus.halt = 1'b1;
    #1;
    chk("halt_no_read", 32'(bus.fifo_read), 32'd0);
    tick();
    bus.m_ready = 1'b1;
    #1;
    chk("halt_ready_no_read", 32'(bus.fifo_read), 32'd0);
    tick();
    chk("halt_drained", 32'(bus.m_valid), 32'd0);
    bus.halt = 1'b0;
    tick(10);

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      bus.m_ready = ($urandom_range(0, 3) != 0);
      bus.halt    = ($urandom_range(0, 7) == 0);
      bus.flux_en = ($urandom_range(0, 3) != 0) ? 2'b11 : FLUX'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        int s = $urandom_range(0, FLUX - 1);
        if (mq[s].size() < 40) push_ok(s);
      end
      tick();
    end
    bus.m_ready = 1'b1;
    bus.halt    = 1'b0;
    bus.flux_en = '1;
    tick(100);
    chk("rand_drained", 32'(mq[0].size() + mq[1].size()), 32'd0);

    // Tag mismatch is sticky
    chk("tag_err_clean", 32'(bus.tag_err), 32'd0);
    bad = {1'b1, 8'hA5};
    push(0, bad);
    tick(2);
    chk("tag_err_set", 32'(bus.tag_err), 32'd1);
    tick(5);
    chk("tag_err_sticky", 32'(bus.tag_err), 32'd1);

    // Reset mid-transfer: beat discarded, order restarts at stream 0
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_ok(0);
      push_ok(1);
    end
    wait_valid("mid_valid");
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.m_valid), 32'd0);
    chk("mid_rst_data", 32'(bus.m_data), 32'd0);
    chk("mid_rst_tag_err", 32'(bus.tag_err), 32'd0);
    chk("mid_rst_read", 32'(bus.fifo_read), 32'd0);
    tick(2);
    pop_log.delete();
    bus.m_ready = 1'b1;
    rst = 1'b1;
    tick(3);
    chk("restart_pops", 32'(pop_log.size() != 0), 32'd1);
    if (pop_log.size() != 0) chk("restart_stream", 32'(pop_log[0]), 32'd0);
    tick(20);
    chk("final_drained", 32'(mq[0].size() + mq[1].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
